memory_bus_arbiter: RTL and testbench

Parametrised N-to-1 arbiter for the MemoryBus valid/taken protocol, with requester ports flattened into packed vectors. It merges PORTS requester-side buses (ray tracer cores, config loaders, frame readers) onto one downstream memory bus through a registered request slice with round-robin fairness. Responses are routed back by master ID field. It replaces per-client hand wiring of single-master buses at the memory controller.

---
 rtl/memory_bus_arbiter_pkg.sv | 44 ++++
 rtl/memory_bus_arbiter_rr_picker.sv | 25 ++
 rtl/memory_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and helpers for the MemoryBus arbiter family.
// Holds the index-width helper, the default-width request record and the
// round-robin search function used by rr_picker.
package memory_bus_pkg;

    // Largest requester count any arbiter in this family supports
    localparam int MAX_PORTS = 16;

    // Request record at the default bus widths, for clients that do not
    // re-parametrise the bus
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] address;
        logic [23:0] data;
        logic        write;
    } req_rec_t;

    // Number of bits needed to name one of 'ports' requesters (never 0)
    function automatic int port_idx_w(input int ports);
        return (ports <= 2) ? 1 : $clog2(ports);
    endfunction

    // First set bit of 'valid' at or after 'start', wrapping at 'ports'.
    // Returns 'start' when nothing is set; callers qualify with their own
    // found flag.
    function automatic logic [3:0] pick_rr(input logic [MAX_PORTS-1:0] valid,
                                           input logic [3:0]           start,
                                           input int                   ports);
        logic [3:0] result;
        logic       hit;
        int         p;
        result = start;
        hit    = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            p = (int'(start) + k) % ports;
            if (k < ports && !hit && valid[p[3:0]]) begin
                result = p[3:0];
                hit    = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: rotates the priority so that the search
// begins at 'start', and reports whether any requester is valid at all.
module rr_picker
    import memory_bus_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IW    = port_idx_w(PORTS)
) (
    input  logic [PORTS-1:0] valid,
    input  logic [IW-1:0]    start,
    output logic [IW-1:0]    grant,
    output logic             found
);

    logic [MAX_PORTS-1:0] validWide;

    // Widen the request vector and run the wrap-around priority search
    always_comb begin
        validWide            = '0;
        validWide[PORTS-1:0] = valid;
        grant                = IW'(pick_rr(validWide, 4'(start), PORTS));
        found                = |valid;
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// N-to-1 MemoryBus arbiter. Requests from PORTS requesters are merged onto a
// single downstream bus through a one-entry registered slice with round-robin
// fairness (optionally holding the grant for short bursts). Responses are
// steered back combinationally using a port index carried in the master ID.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 8,
    parameter int PORT_SHIFT      = 2,
    parameter bit HOLD_GRANT      = 1'b0,
    parameter int BURST_MAX       = 8
) (
    input  logic                               clock,
    input  logic                               reset,

    input  logic [PORTS*MASTER_ID_WIDTH-1:0]   umsID,
    input  logic [PORTS*ADDRESS_WIDTH-1:0]     umsAddress,
    input  logic [PORTS*DATA_WIDTH-1:0]        umsData,
    input  logic [PORTS-1:0]                   umsWrite,
    input  logic [PORTS-1:0]                   umsValid,
    output logic [PORTS-1:0]                   umsTaken,

    output logic [PORTS*MASTER_ID_WIDTH-1:0]   usmID,
    output logic [PORTS*DATA_WIDTH-1:0]        usmData,
    output logic [PORTS-1:0]                   usmValid,
    input  logic [PORTS-1:0]                   usmTaken,

    output logic [MASTER_ID_WIDTH-1:0]         dmsID,
    output logic [ADDRESS_WIDTH-1:0]           dmsAddress,
    output logic [DATA_WIDTH-1:0]              dmsData,
    output logic                               dmsWrite,
    output logic                               dmsValid,
    input  logic                               dmsTaken,

    input  logic [MASTER_ID_WIDTH-1:0]         dsmID,
    input  logic [DATA_WIDTH-1:0]              dsmData,
    input  logic                               dsmValid,
    output logic                               dsmTaken,

    output logic                               routeError
);

    localparam int              IW          = port_idx_w(PORTS);
    localparam int              CW          = $clog2(BURST_MAX + 1);
    localparam logic [IW-1:0]   LAST_PORT   = IW'(PORTS - 1);
    localparam logic [CW-1:0]   BURST_LIMIT = CW'(BURST_MAX);

    typedef struct packed {
        logic [MASTER_ID_WIDTH-1:0] id;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [DATA_WIDTH-1:0]      data;
        logic                       write;
    } slice_t;

    logic            full;
    slice_t          slice;
    slice_t          picked;

    logic [IW-1:0]   lastGrant;
    logic [IW-1:0]   rrStart;
    logic [IW-1:0]   rrGrant;
    logic            rrFound;
    logic [IW-1:0]   grantIdx;
    logic            holdWin;
    logic            canLoad;
    logic            loadReq;
    logic [CW-1:0]   beatCount;

    logic [IW-1:0]   respIdx;
    logic            respInRange;

    // Fair search begins one past the most recently granted port
    always_comb begin
        rrStart = (lastGrant == LAST_PORT) ? '0 : lastGrant + 1'b1;
    end

    rr_picker #(
        .PORTS (PORTS)
    ) picker (
        .valid (umsValid),
        .start (rrStart),
        .grant (rrGrant),
        .found (rrFound)
    );

    // Burst hold: the last winner keeps the bus while it stays valid and has
    // beats left; a zero count means nothing has been granted since reset
    always_comb begin
        holdWin = 1'b0;
        if (HOLD_GRANT && beatCount != '0 && beatCount < BURST_LIMIT) begin
            holdWin = umsValid[lastGrant];
        end
    end

    // Decide whether the slice accepts a new beat this cycle and from whom
    always_comb begin
        canLoad  = !full || dmsTaken;
        grantIdx = holdWin ? lastGrant : rrGrant;
        loadReq  = canLoad && rrFound;
    end

    // One-hot accept back to the winning requester, silent during reset
    always_comb begin
        umsTaken = '0;
        for (int p = 0; p < PORTS; p++) begin
            umsTaken[p] = loadReq && !reset && (grantIdx == IW'(p));
        end
    end

    // Gather the winning requester's fields from the flattened buses
    always_comb begin
        picked = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (grantIdx == IW'(p)) begin
                picked.id      = umsID[p*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
                picked.address = umsAddress[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                picked.data    = umsData[p*DATA_WIDTH +: DATA_WIDTH];
                picked.write   = umsWrite[p];
            end
        end
    end

    // Request slice: load replaces (even while draining), otherwise empty on drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            slice <= '0;
        end else if (loadReq) begin
            full  <= 1'b1;
            slice <= picked;
        end else if (dmsTaken) begin
            full  <= 1'b0;
        end
    end

    // Remember the last winner and how many back-to-back beats it has had
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lastGrant <= LAST_PORT;
            beatCount <= '0;
        end else if (loadReq) begin
            lastGrant <= grantIdx;
            if (grantIdx == lastGrant && beatCount != '0) begin
                if (beatCount != BURST_LIMIT) begin
                    beatCount <= beatCount + 1'b1;
                end
            end else begin
                beatCount <= CW'(1);
            end
        end
    end

    assign dmsValid   = full;
    assign dmsID      = slice.id;
    assign dmsAddress = slice.address;
    assign dmsData    = slice.data;
    assign dmsWrite   = slice.write;

    // Decode which requester a response belongs to
    always_comb begin
        respIdx     = dsmID[PORT_SHIFT +: IW];
        respInRange = int'(respIdx) < PORTS;
    end

    // Steer valid to the addressed port and return its accept; responses to
    // a non-existent port are swallowed so the memory side never stalls
    always_comb begin
        usmValid = '0;
        dsmTaken = !respInRange;
        for (int p = 0; p < PORTS; p++) begin
            if (respInRange && respIdx == IW'(p)) begin
                usmValid[p] = dsmValid;
                dsmTaken    = usmTaken[p];
            end
        end
    end

    assign usmID   = {PORTS{dsmID}};
    assign usmData = {PORTS{dsmData}};

    // Sticky flag for misrouted responses, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            routeError <= 1'b0;
        end else if (dsmValid && !respInRange) begin
            routeError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: round-robin, backpressure,
// response steering, reset mid-transfer, burst hold and out-of-range routing.
module tb_memory_bus_arbiter;

    logic clock;
    logic rstA, rstB, rstC;

    // DUT A: default parameters
    logic [31:0]  umsIDA;
    logic [127:0] umsAddressA;
    logic [95:0]  umsDataA;
    logic [3:0]   umsWriteA, umsValidA, umsTakenA;
    logic [31:0]  usmIDA;
    logic [95:0]  usmDataA;
    logic [3:0]   usmValidA, usmTakenA;
    logic [7:0]   dmsIDA;
    logic [31:0]  dmsAddressA;
    logic [23:0]  dmsDataA;
    logic         dmsWriteA, dmsValidA, dmsTakenA;
    logic [7:0]   dsmIDA;
    logic [23:0]  dsmDataA;
    logic         dsmValidA, dsmTakenA, routeErrorA;

    // DUT B: burst hold, BURST_MAX=3
    logic [31:0]  umsIDB;
    logic [127:0] umsAddressB;
    logic [95:0]  umsDataB;
    logic [3:0]   umsWriteB, umsValidB, umsTakenB;
    logic [31:0]  usmIDB;
    logic [95:0]  usmDataB;
    logic [3:0]   usmValidB, usmTakenB;
    logic [7:0]   dmsIDB;
    logic [31:0]  dmsAddressB;
    logic [23:0]  dmsDataB;
    logic         dmsWriteB, dmsValidB, dmsTakenB;
    logic [7:0]   dsmIDB;
    logic [23:0]  dsmDataB;
    logic         dsmValidB, dsmTakenB, routeErrorB;

    // DUT C: three ports
    logic [23:0]  umsIDC;
    logic [95:0]  umsAddressC;
    logic [71:0]  umsDataC;
    logic [2:0]   umsWriteC, umsValidC, umsTakenC;
    logic [23:0]  usmIDC;
    logic [71:0]  usmDataC;
    logic [2:0]   usmValidC, usmTakenC;
    logic [7:0]   dmsIDC;
    logic [31:0]  dmsAddressC;
    logic [23:0]  dmsDataC;
    logic         dmsWriteC, dmsValidC, dmsTakenC;
    logic [7:0]   dsmIDC;
    logic [23:0]  dsmDataC;
    logic         dsmValidC, dsmTakenC, routeErrorC;

    int total = 0;
    int bad   = 0;

    logic [64:0] expA[$];
    logic [7:0]  expB[$];
    logic [64:0] expBeatA;
    logic [7:0]  expBeatB;

    memory_bus_arbiter dutA (
        .clock(clock), .reset(rstA),
        .umsID(umsIDA), .umsAddress(umsAddressA), .umsData(umsDataA),
        .umsWrite(umsWriteA), .umsValid(umsValidA), .umsTaken(umsTakenA),
        .usmID(usmIDA), .usmData(usmDataA), .usmValid(usmValidA), .usmTaken(usmTakenA),
        .dmsID(dmsIDA), .dmsAddress(dmsAddressA), .dmsData(dmsDataA),
        .dmsWrite(dmsWriteA), .dmsValid(dmsValidA), .dmsTaken(dmsTakenA),
        .dsmID(dsmIDA), .dsmData(dsmDataA), .dsmValid(dsmValidA), .dsmTaken(dsmTakenA),
        .routeError(routeErrorA)
    );

    memory_bus_arbiter #(.HOLD_GRANT(1'b1), .BURST_MAX(3)) dutB (
        .clock(clock), .reset(rstB),
        .umsID(umsIDB), .umsAddress(umsAddressB), .umsData(umsDataB),
        .umsWrite(umsWriteB), .umsValid(umsValidB), .umsTaken(umsTakenB),
        .usmID(usmIDB), .usmData(usmDataB), .usmValid(usmValidB), .usmTaken(usmTakenB),
        .dmsID(dmsIDB), .dmsAddress(dmsAddressB), .dmsData(dmsDataB),
        .dmsWrite(dmsWriteB), .dmsValid(dmsValidB), .dmsTaken(dmsTakenB),
        .dsmID(dsmIDB), .dsmData(dsmDataB), .dsmValid(dsmValidB), .dsmTaken(dsmTakenB),
        .routeError(routeErrorB)
    );

    memory_bus_arbiter #(.PORTS(3)) dutC (
        .clock(clock), .reset(rstC),
        .umsID(umsIDC), .umsAddress(umsAddressC), .umsData(umsDataC),
        .umsWrite(umsWriteC), .umsValid(umsValidC), .umsTaken(umsTakenC),
        .usmID(usmIDC), .usmData(usmDataC), .usmValid(usmValidC), .usmTaken(usmTakenC),
        .dmsID(dmsIDC), .dmsAddress(dmsAddressC), .dmsData(dmsDataC),
        .dmsWrite(dmsWriteC), .dmsValid(dmsValidC), .dmsTaken(dmsTakenC),
        .dsmID(dsmIDC), .dsmData(dsmDataC), .dsmValid(dsmValidC), .dsmTaken(dsmTakenC),
        .routeError(routeErrorC)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop if the sequence ever stalls
    initial begin
        #50000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one requester beat on DUT A
    task automatic applyStimulus(input int port, input logic v, input logic [7:0] id, input logic [23:0] data);
        umsValidA[port]             = v;
        umsIDA[port*8 +: 8]         = id;
        umsAddressA[port*32 +: 32]  = 32'h1000_0000 + 32'(port * 16);
        umsDataA[port*24 +: 24]     = data;
        umsWriteA[port]             = 1'(port % 2);
    endtask

    function automatic logic [64:0] mkBeat(input int port, input logic [7:0] id, input logic [23:0] data);
        return {id, 32'h1000_0000 + 32'(port * 16), data, 1'(port % 2)};
    endfunction

    // Scoreboard monitor for DUT A: every downstream transfer must match the queue head
    always @(negedge clock) begin
        if (dmsValidA && dmsTakenA) begin
            if (expA.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL beatA unexpected actual=%0h required=none", dmsIDA);
            end else begin
                expBeatA = expA.pop_front();
                checkOutput("beatA", {dmsIDA, dmsAddressA, dmsDataA, dmsWriteA}, 128'(expBeatA));
            end
        end
        checkOutput("takeLegalA", 128'(umsTakenA & ~umsValidA), 128'(0));
        checkOutput("takeOneHotA", 128'($onehot0(umsTakenA)), 128'(1));
    end

    // Scoreboard monitor for DUT B: grant order observed through the forwarded IDs
    always @(negedge clock) begin
        if (dmsValidB && dmsTakenB) begin
            if (expB.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL beatB unexpected actual=%0h required=none", dmsIDB);
            end else begin
                expBeatB = expB.pop_front();
                checkOutput("beatB", 128'(dmsIDB), 128'(expBeatB));
            end
        end
        checkOutput("takeOneHotB", 128'($onehot0(umsTakenB)), 128'(1));
    end

    initial begin
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        umsIDA = '0; umsAddressA = '0; umsDataA = '0; umsWriteA = '0; umsValidA = '0;
        usmTakenA = '0; dmsTakenA = 1'b1; dsmIDA = '0; dsmDataA = '0; dsmValidA = 1'b0;
        umsIDB = '0; umsAddressB = '0; umsDataB = '0; umsWriteB = '0; umsValidB = '0;
        usmTakenB = '0; dmsTakenB = 1'b1; dsmIDB = '0; dsmDataB = '0; dsmValidB = 1'b0;
        umsIDC = '0; umsAddressC = '0; umsDataC = '0; umsWriteC = '0; umsValidC = '0;
        usmTakenC = '0; dmsTakenC = 1'b1; dsmIDC = '0; dsmDataC = '0; dsmValidC = 1'b0;
        repeat (2) tick();

        // Round robin over four always-valid ports
        for (int p = 0; p < 4; p++) applyStimulus(p, 1'b1, 8'(p * 4), 24'(256 + p));
        #1;
        checkOutput("resetDmsValid", 128'(dmsValidA), 128'(0));
        checkOutput("resetUmsTaken", 128'(umsTakenA), 128'(0));
        checkOutput("resetDmsID", 128'(dmsIDA), 128'(0));
        checkOutput("resetRouteError", 128'(routeErrorA), 128'(0));
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) expA.push_back(mkBeat(p, 8'(p * 4), 24'(256 + p)));
        rstA = 1'b0;
        #1;
        checkOutput("firstTakePort0", 128'(umsTakenA), 128'(4'b0001));
        checkOutput("noValidBeforeEdge", 128'(dmsValidA), 128'(0));
        tick();
        checkOutput("latencyOneCycle", 128'(dmsValidA), 128'(1));
        repeat (7) tick();
        umsValidA = '0;
        tick();
        #1;
        checkOutput("drainedEmpty", 128'(dmsValidA), 128'(0));

        // Backpressure with only port 2 requesting
        dmsTakenA = 1'b0;
        applyStimulus(2, 1'b1, 8'h08, 24'h000AAA);
        #1;
        checkOutput("bpFirstTake", 128'(umsTakenA), 128'(4'b0100));
        expA.push_back(mkBeat(2, 8'h08, 24'h000AAA));
        expA.push_back(mkBeat(2, 8'h08, 24'h000BBB));
        tick();
        applyStimulus(2, 1'b1, 8'h08, 24'h000BBB);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bpHeldValid", 128'(dmsValidA), 128'(1));
            checkOutput("bpHeldData", 128'(dmsDataA), 128'(24'h000AAA));
            checkOutput("bpHeldID", 128'(dmsIDA), 128'(8'h08));
            checkOutput("bpNoTake", 128'(umsTakenA), 128'(0));
            tick();
        end
        dmsTakenA = 1'b1;
        #1;
        checkOutput("bpResumeTake", 128'(umsTakenA), 128'(4'b0100));
        tick();
        applyStimulus(2, 1'b0, 8'h08, 24'h000BBB);
        tick();
        #1;
        checkOutput("bpDrained", 128'(dmsValidA), 128'(0));

        // Response routing by ID bits [3:2]
        dsmIDA = 8'h09; dsmDataA = 24'h123456; dsmValidA = 1'b1; usmTakenA = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("respStallValid", 128'(usmValidA), 128'(4'b0100));
            checkOutput("respStallTaken", 128'(dsmTakenA), 128'(0));
            tick();
        end
        #1;
        checkOutput("respBroadcastID", 128'(usmIDA), 128'({4{8'h09}}));
        checkOutput("respBroadcastData", 128'(usmDataA), 128'({4{24'h123456}}));
        usmTakenA = 4'b0100;
        #1;
        checkOutput("respAccept", 128'(dsmTakenA), 128'(1));
        checkOutput("respAcceptValid", 128'(usmValidA), 128'(4'b0100));
        tick();
        dsmIDA = 8'h01; usmTakenA = 4'b0010;
        #1;
        checkOutput("respPort0Valid", 128'(usmValidA), 128'(4'b0001));
        checkOutput("respWrongTaken", 128'(dsmTakenA), 128'(0));
        dsmValidA = 1'b0;
        #1;
        checkOutput("respIdle", 128'(usmValidA), 128'(0));
        tick();

        // Reset while the slice holds a stalled beat
        dmsTakenA = 1'b0;
        applyStimulus(0, 1'b1, 8'h00, 24'h000444);
        tick();
        #1;
        checkOutput("midFull", 128'(dmsValidA), 128'(1));
        checkOutput("midHeldTake", 128'(umsTakenA), 128'(0));
        rstA = 1'b1;
        #1;
        checkOutput("midResetValid", 128'(dmsValidA), 128'(0));
        checkOutput("midResetTake", 128'(umsTakenA), 128'(0));
        tick();
        applyStimulus(1, 1'b1, 8'h04, 24'h000555);
        dmsTakenA = 1'b1;
        expA.push_back(mkBeat(0, 8'h00, 24'h000444));
        expA.push_back(mkBeat(1, 8'h04, 24'h000555));
        rstA = 1'b0;
        #1;
        checkOutput("restartPort0", 128'(umsTakenA), 128'(4'b0001));
        tick();
        tick();
        umsValidA = '0;
        tick();
        #1;
        checkOutput("restartDrained", 128'(dmsValidA), 128'(0));

        // Burst hold on DUT B: ports 0 and 1 always valid
        umsValidB = 4'b0011;
        umsIDB[7:0] = 8'h00;
        umsIDB[15:8] = 8'h04;
        expB.push_back(8'h00); expB.push_back(8'h00); expB.push_back(8'h00);
        expB.push_back(8'h04); expB.push_back(8'h04); expB.push_back(8'h04);
        expB.push_back(8'h00); expB.push_back(8'h00); expB.push_back(8'h00);
        #1;
        checkOutput("holdResetTake", 128'(umsTakenB), 128'(0));
        rstB = 1'b0;
        #1;
        checkOutput("holdFirstTake", 128'(umsTakenB), 128'(4'b0001));
        repeat (9) tick();
        umsValidB = '0;
        repeat (2) tick();

        // Out-of-range response on the three-port DUT C
        #1;
        checkOutput("routeResetClear", 128'(routeErrorC), 128'(0));
        rstC = 1'b0;
        dsmIDC = 8'h0C; dsmValidC = 1'b1; usmTakenC = '0;
        #1;
        checkOutput("routeBadTaken", 128'(dsmTakenC), 128'(1));
        checkOutput("routeBadValid", 128'(usmValidC), 128'(0));
        checkOutput("routeNotYet", 128'(routeErrorC), 128'(0));
        tick();
        checkOutput("routeErrorSet", 128'(routeErrorC), 128'(1));
        dsmValidC = 1'b0;
        repeat (3) tick();
        checkOutput("routeErrorSticky", 128'(routeErrorC), 128'(1));
        dsmIDC = 8'h04; dsmValidC = 1'b1;
        #1;
        checkOutput("routeGoodValid", 128'(usmValidC), 128'(3'b010));
        checkOutput("routeGoodStall", 128'(dsmTakenC), 128'(0));
        usmTakenC = 3'b010;
        #1;
        checkOutput("routeGoodAccept", 128'(dsmTakenC), 128'(1));
        dsmValidC = 1'b0;
        rstC = 1'b1;
        #1;
        checkOutput("routeErrorCleared", 128'(routeErrorC), 128'(0));

        // Every queued beat must have been seen
        for (int w = 0; w < 20 && (expA.size() != 0 || expB.size() != 0); w++) tick();
        checkOutput("queueAEmpty", 128'(expA.size()), 128'(0));
        checkOutput("queueBEmpty", 128'(expB.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
